// File: rtl/fp_op_sequencer.sv
// Issues ADDF/MULTF from EX to the shared multi-cycle FP core and stalls the pipeline until the result returns.
// Optional watchdog on the core handshake is enabled with `define FPU_TIMEOUT_EN.
module fp_op_sequencer #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_i,
  input  logic              op_is_mul_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic [REG_W-1:0]  dest_i,
  input  logic              flush_i,
  output logic              fpu_start_o,
  output logic              fpu_op_o,
  output logic [DATA_W-1:0] fpu_a_o,
  output logic [DATA_W-1:0] fpu_b_o,
  input  logic              fpu_done_i,
  input  logic [DATA_W-1:0] fpu_result_i,
  output logic              stall_o,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] res_data_o,
  output logic [REG_W-1:0]  res_dest_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t            state;
  logic              op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [REG_W-1:0]  dest_q;
  logic [DATA_W-1:0] res_q;
  logic [REG_W-1:0]  res_dest_q;
  logic              err_q;
  logic              wd_expired;

`ifdef FPU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wd_cnt;

  // Counts cycles spent waiting on the core; restarts whenever WAIT or DRAIN is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT && flush_i) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT || state == S_DRAIN) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_expired = (wd_cnt == CNT_LAST);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      dest_q     <= '0;
      res_q      <= '0;
      res_dest_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid_i && !flush_i) begin
            op_q   <= op_is_mul_i;
            a_q    <= opa_i;
            b_q    <= opb_i;
            dest_q <= dest_i;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= flush_i ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          // A result arriving alongside a flush belongs to a squashed op, so drop it.
          if (fpu_done_i && flush_i) begin
            state <= S_IDLE;
          end else if (fpu_done_i) begin
            res_q      <= fpu_result_i;
            res_dest_q <= dest_q;
            state      <= S_DONE;
          end else if (flush_i) begin
            state <= S_DRAIN;
          end else if (wd_expired) begin
            err_q      <= 1'b1;
            res_q      <= '0;
            res_dest_q <= dest_q;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_DRAIN: begin
          if (fpu_done_i) begin
            state <= S_IDLE;
          end else if (wd_expired) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // DONE drops the stall so EX advances on the same edge the result is captured by EX/MEM.
  always_comb begin
    stall_o = 1'b0;
    case (state)
      S_IDLE:          stall_o = op_valid_i && !flush_i;
      S_ISSUE, S_WAIT: stall_o = 1'b1;
      S_DRAIN:         stall_o = op_valid_i;
      default:         stall_o = 1'b0;
    endcase
  end

  assign fpu_start_o = (state == S_ISSUE);
  assign fpu_op_o    = op_q;
  assign fpu_a_o     = a_q;
  assign fpu_b_o     = b_q;
  assign res_valid_o = (state == S_DONE) && !flush_i;
  assign res_data_o  = res_q;
  assign res_dest_o  = res_dest_q;
  assign busy_o      = (state != S_IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Self-checking bench for fp_op_sequencer: a stub FP core with programmable latency plus
// per-scenario timelines derived from operation latency (core latency + 2 cycles).
module tb_fp_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid_i = 1'b0;
  logic        op_is_mul_i = 1'b0;
  logic [15:0] opa_i = '0;
  logic [15:0] opb_i = '0;
  logic [3:0]  dest_i = '0;
  logic        flush_i = 1'b0;
  logic        fpu_start_o;
  logic        fpu_op_o;
  logic [15:0] fpu_a_o;
  logic [15:0] fpu_b_o;
  logic        fpu_done_i;
  logic [15:0] fpu_result_i;
  logic        stall_o;
  logic        res_valid_o;
  logic [15:0] res_data_o;
  logic [3:0]  res_dest_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  // Stub core state: a start at cycle s raises done at cycle s + core_lat.
  int          cyc = 0;
  int          done_at = -1;
  int          core_lat = 1;
  logic        spur_done = 1'b0;
  logic        core_force_en = 1'b0;
  logic [15:0] core_force_val = '0;
  logic [15:0] core_res = '0;
  int          start_log[$];

  fp_op_sequencer #(.DATA_W(16), .REG_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid_i), .op_is_mul_i(op_is_mul_i),
    .opa_i(opa_i), .opb_i(opb_i), .dest_i(dest_i), .flush_i(flush_i),
    .fpu_start_o(fpu_start_o), .fpu_op_o(fpu_op_o),
    .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o),
    .fpu_done_i(fpu_done_i), .fpu_result_i(fpu_result_i),
    .stall_o(stall_o), .res_valid_o(res_valid_o),
    .res_data_o(res_data_o), .res_dest_o(res_dest_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(input logic op, input logic [15:0] a, input logic [15:0] b);
    return op ? 16'(a * b) : 16'(a + b);
  endfunction

  always @(posedge clk) begin
    if (fpu_start_o) begin
      done_at  <= cyc + core_lat;
      core_res <= core_force_en ? core_force_val : ref_result(fpu_op_o, fpu_a_o, fpu_b_o);
      start_log.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  assign fpu_done_i   = (cyc == done_at) || spur_done;
  assign fpu_result_i = core_res;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op from IDLE through DONE; the op stays in EX until the stall drops.
  task automatic run_single(input string tag, input logic op, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] dest, input int lat, input logic flush_done);
    logic [15:0] exp_res;
    exp_res     = core_force_en ? core_force_val : ref_result(op, a, b);
    core_lat    = lat;
    op_valid_i  = 1'b1;
    op_is_mul_i = op;
    opa_i       = a;
    opb_i       = b;
    dest_i      = dest;
    flush_i     = 1'b0;
    for (int k = 0; k <= lat + 2; k++) begin
      if (flush_done && k == lat + 2) flush_i = 1'b1;
      @(negedge clk);
      checks++; if (stall_o !== (k <= lat + 1)) begin errors++; $display("[TB] FAIL %s stall k=%0d got %b exp %b", tag, k, stall_o, (k <= lat + 1)); end
      checks++; if (fpu_start_o !== (k == 1)) begin errors++; $display("[TB] FAIL %s start k=%0d got %b exp %b", tag, k, fpu_start_o, (k == 1)); end
      checks++; if (busy_o !== (k != 0)) begin errors++; $display("[TB] FAIL %s busy k=%0d got %b exp %b", tag, k, busy_o, (k != 0)); end
      checks++; if (res_valid_o !== (k == lat + 2 && !flush_done)) begin errors++; $display("[TB] FAIL %s res_valid k=%0d got %b exp %b", tag, k, res_valid_o, (k == lat + 2 && !flush_done)); end
      if (k == 1 || k == lat + 2) begin
        checks++; if (fpu_a_o !== a || fpu_b_o !== b || fpu_op_o !== op) begin errors++; $display("[TB] FAIL %s fpu_operands k=%0d got %h %h %b exp %h %h %b", tag, k, fpu_a_o, fpu_b_o, fpu_op_o, a, b, op); end
      end
      if (k == lat + 2 && !flush_done) begin
        checks++; if (res_data_o !== exp_res) begin errors++; $display("[TB] FAIL %s res_data got %h exp %h", tag, res_data_o, exp_res); end
        checks++; if (res_dest_o !== dest) begin errors++; $display("[TB] FAIL %s res_dest got %0d exp %0d", tag, res_dest_o, dest); end
      end
      tick();
    end
    op_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({fpu_start_o, fpu_op_o, fpu_a_o, fpu_b_o, stall_o, res_valid_o, res_data_o, res_dest_o, busy_o, err_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs got start=%b op=%b a=%h b=%h stall=%b rv=%b data=%h dest=%h busy=%b err=%b exp all 0",
                         fpu_start_o, fpu_op_o, fpu_a_o, fpu_b_o, stall_o, res_valid_o, res_data_o, res_dest_o, busy_o, err_o);
    end
    tick();
  endtask

  task automatic test_addf_example();
    core_force_en  = 1'b1;
    core_force_val = 16'h4200;
    run_single("addf_example", 1'b0, 16'h3C00, 16'h4000, 4'd3, 3, 1'b0);
    core_force_en  = 1'b0;
  endtask

  task automatic test_back_to_back();
    start_log.delete();
    run_single("b2b_mul", 1'b1, 16'h0123, 16'h0045, 4'd7, 4, 1'b0);
    run_single("b2b_add", 1'b0, 16'h1111, 16'h2222, 4'd12, 4, 1'b0);
    checks++;
    if (start_log.size() != 2) begin
      errors++; $display("[TB] FAIL b2b_start_count got %0d exp 2", start_log.size());
    end else if (start_log[1] - start_log[0] != 7) begin
      errors++; $display("[TB] FAIL b2b_start_spacing got %0d exp 7", start_log[1] - start_log[0]);
    end
  endtask

  task automatic test_flush_wait();
    // Flush in WAIT with done two cycles later; a new op waits in EX during DRAIN.
    core_lat    = 5;
    op_valid_i  = 1'b1;
    op_is_mul_i = 1'b1;
    opa_i       = 16'h00AA;
    opb_i       = 16'h0003;
    dest_i      = 4'd5;
    for (int k = 0; k <= 6; k++) begin
      if (k == 4) begin flush_i = 1'b1; op_valid_i = 1'b0; end
      if (k == 5) flush_i = 1'b0;
      if (k == 6) begin op_valid_i = 1'b1; op_is_mul_i = 1'b0; opa_i = 16'h0100; opb_i = 16'h0020; dest_i = 4'd9; end
      @(negedge clk);
      checks++; if (res_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait res_valid k=%0d got %b exp 0", k, res_valid_o); end
      checks++; if (busy_o !== (k != 0)) begin errors++; $display("[TB] FAIL flush_wait busy k=%0d got %b exp %b", k, busy_o, (k != 0)); end
      if (k == 5) begin
        checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait drain_stall got %b exp 0", stall_o); end
      end
      if (k == 6) begin
        checks++; if (stall_o !== 1'b1 || fpu_start_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait drain_new_op stall=%b start=%b exp 1 0", stall_o, fpu_start_o); end
      end
      tick();
    end
    run_single("after_drain", 1'b0, 16'h0100, 16'h0020, 4'd9, 2, 1'b0);

    // Flush and done in the same WAIT cycle discard the result and return to IDLE.
    core_lat    = 3;
    op_valid_i  = 1'b1;
    op_is_mul_i = 1'b0;
    opa_i       = 16'h0007;
    opb_i       = 16'h0008;
    dest_i      = 4'd2;
    for (int k = 0; k <= 6; k++) begin
      if (k == 4) begin flush_i = 1'b1; op_valid_i = 1'b0; end
      if (k == 5) flush_i = 1'b0;
      @(negedge clk);
      checks++; if (res_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_and_done res_valid k=%0d got %b exp 0", k, res_valid_o); end
      checks++; if (busy_o !== (k >= 1 && k <= 4)) begin errors++; $display("[TB] FAIL flush_and_done busy k=%0d got %b exp %b", k, busy_o, (k >= 1 && k <= 4)); end
      tick();
    end
  endtask

  task automatic test_flush_done();
    run_single("flush_done", 1'b1, 16'h0011, 16'h0022, 4'd4, 2, 1'b1);
    @(negedge clk);
    checks++; if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_done_after busy=%b rv=%b exp 0 0", busy_o, res_valid_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    core_lat    = 4;
    op_valid_i  = 1'b1;
    op_is_mul_i = 1'b1;
    opa_i       = 16'hBEEF;
    opb_i       = 16'h1234;
    dest_i      = 4'd14;
    for (int k = 0; k <= 6; k++) begin
      if (k == 3) begin rst = 1'b1; op_valid_i = 1'b0; end
      if (k == 4) rst = 1'b0;
      @(negedge clk);
      if (k == 4) begin
        checks++; if ({fpu_start_o, fpu_op_o, fpu_a_o, fpu_b_o, stall_o, res_valid_o, res_data_o, res_dest_o, busy_o, err_o} !== '0) begin
          errors++; $display("[TB] FAIL reset_mid_outputs a=%h b=%h op=%b data=%h dest=%h busy=%b stall=%b exp all 0",
                             fpu_a_o, fpu_b_o, fpu_op_o, res_data_o, res_dest_o, busy_o, stall_o);
        end
      end
      if (k >= 5) begin
        checks++; if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_done_ignored k=%0d busy=%b rv=%b exp 0 0", k, busy_o, res_valid_o); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dest;
    int          gap;
    for (int i = 0; i < 25; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        // Idle cycles: stray done pulses and flushed EX ops must not start anything.
        flush_i    = 1'($urandom_range(0, 1));
        op_valid_i = flush_i & 1'($urandom_range(0, 1));
        spur_done  = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || stall_o !== 1'b0 || res_valid_o !== 1'b0) begin
          errors++; $display("[TB] FAIL random_idle i=%0d busy=%b stall=%b rv=%b exp 0 0 0", i, busy_o, stall_o, res_valid_o);
        end
        tick();
        spur_done  = 1'b0;
        flush_i    = 1'b0;
        op_valid_i = 1'b0;
      end
      op   = 1'($urandom_range(0, 1));
      a    = 16'($urandom);
      b    = 16'($urandom);
      dest = 4'($urandom_range(0, 15));
      run_single("random", op, a, b, dest, $urandom_range(1, 6), 1'b0);
    end
  endtask

  task automatic test_timeout();
    core_lat    = 100000;
    op_valid_i  = 1'b1;
    op_is_mul_i = 1'b0;
    opa_i       = 16'h0F0F;
    opb_i       = 16'h00F0;
    dest_i      = 4'd11;
`ifdef FPU_TIMEOUT_EN
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      checks++; if (stall_o !== (k <= 17)) begin errors++; $display("[TB] FAIL timeout stall k=%0d got %b exp %b", k, stall_o, (k <= 17)); end
      checks++; if (err_o !== (k == 18)) begin errors++; $display("[TB] FAIL timeout err k=%0d got %b exp %b", k, err_o, (k == 18)); end
      checks++; if (res_valid_o !== (k == 18)) begin errors++; $display("[TB] FAIL timeout res_valid k=%0d got %b exp %b", k, res_valid_o, (k == 18)); end
      if (k == 18) begin
        checks++; if (res_data_o !== 16'h0000 || res_dest_o !== 4'd11) begin errors++; $display("[TB] FAIL timeout result data=%h dest=%0d exp 0000 11", res_data_o, res_dest_o); end
      end
      tick();
    end
    op_valid_i = 1'b0;
    for (int k = 19; k <= 22; k++) begin
      @(negedge clk);
      checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL timeout_sticky k=%0d err=%b busy=%b exp 1 0", k, err_o, busy_o); end
      tick();
    end
`else
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      checks++; if (stall_o !== 1'b1 || err_o !== 1'b0 || res_valid_o !== 1'b0) begin
        errors++; $display("[TB] FAIL no_timeout k=%0d stall=%b err=%b rv=%b exp 1 0 0", k, stall_o, err_o, res_valid_o);
      end
      tick();
    end
    op_valid_i = 1'b0;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (err_o !== 1'b0 || busy_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("[TB] FAIL timeout_reset err=%b busy=%b stall=%b exp 0 0 0", err_o, busy_o, stall_o); end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_addf_example();
    test_back_to_back();
    test_flush_wait();
    test_flush_done();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
